mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 tb/tb_mem_access_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage load/store controller for a request/addr_ok/data_ok data bus
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        flush,
  output logic        stall_m,
  output logic [31:0] rdata_m,
  output logic        addr_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_wr;
  // Set when the in-flight transaction was flushed after the slave accepted it;
  // the response must still be drained but its result is discarded.
  logic        cancelled;

  logic access;
  logic aligned;
  logic valid;

  // Decode the memory-stage instruction into a legal word access
  always_comb begin
    access  = memtoreg_m | memwrite_m;
    aligned = (addr_m[1:0] == 2'b00);
    valid   = access & aligned & ~flush;
  end

  // Transaction FSM: latch the request, hold it on the bus until accepted, wait for the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_wr    <= 1'b0;
      rdata_m   <= 32'h0;
      cancelled <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cancelled <= 1'b0;
          if (valid) begin
            lat_addr  <= addr_m;
            lat_wdata <= wdata_m;
            // A store wins when both load and store are flagged
            lat_wr    <= memwrite_m;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              if (flush) begin
                state <= IDLE;
              end else begin
                if (!lat_wr) rdata_m <= data_rdata;
                state <= DONE;
              end
              cancelled <= 1'b0;
            end else begin
              cancelled <= flush;
              state     <= DATA;
            end
          end else if (flush) begin
            // Not yet accepted by the slave, so the request can simply be withdrawn
            state <= IDLE;
          end
        end
        DATA: begin
          if (data_data_ok) begin
            if (flush || cancelled) begin
              state <= IDLE;
            end else begin
              if (!lat_wr) rdata_m <= data_rdata;
              state <= DONE;
            end
            cancelled <= 1'b0;
          end else if (flush) begin
            cancelled <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and pipeline outputs derived from state; IDLE stall reacts to the incoming access the same cycle
  always_comb begin
    data_req   = ~rst & (state == ADDR);
    data_wr    = lat_wr;
    data_addr  = lat_addr;
    data_wdata = lat_wdata;
    addr_err   = ~rst & (state == IDLE) & access & ~aligned & ~flush;
    stall_m    = ~rst & (((state == IDLE) & valid) | (state == ADDR) | (state == DATA));
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memtoreg_m;
  logic        memwrite_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        flush;
  logic        stall_m;
  logic [31:0] rdata_m;
  logic        addr_err;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .memtoreg_m   (memtoreg_m),
    .memwrite_m   (memwrite_m),
    .addr_m       (addr_m),
    .wdata_m      (wdata_m),
    .flush        (flush),
    .stall_m      (stall_m),
    .rdata_m      (rdata_m),
    .addr_err     (addr_err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mtr, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic fl, input logic aok, input logic dok, input logic [31:0] rd);
    memtoreg_m   = mtr;
    memwrite_m   = mw;
    addr_m       = a;
    wdata_m      = wd;
    flush        = fl;
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rd;
  endtask

  task automatic ctl(input string tag, input logic st, input logic rq, input logic er);
    @(negedge clk);
    chk({tag, ".stall"}, {31'b0, stall_m}, {31'b0, st});
    chk({tag, ".req"},   {31'b0, data_req}, {31'b0, rq});
    chk({tag, ".err"},   {31'b0, addr_err}, {31'b0, er});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    // Reset held with a valid load presented: everything quiet
    ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.rdata", rdata_m, 32'h0);
    chk("rst.addr", data_addr, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Load 0x1000, addr_ok in first ADDR cycle, data_ok in third
    ctl("ld.idle", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    ctl("ld.addr", 1'b1, 1'b1, 1'b0);
    chk("ld.addr_bus", data_addr, 32'h0000_1000);
    chk("ld.wr", {31'b0, data_wr}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("ld.data1", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    ctl("ld.data2", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("ld.done", 1'b0, 1'b0, 1'b0);
    chk("ld.rdata", rdata_m, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("ld.after", 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Store (both flags high) to 0x2004, accepted and completed in one cycle
    drive(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("st.idle", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h5555_5555);
    ctl("st.addr", 1'b1, 1'b1, 1'b0);
    chk("st.wr", {31'b0, data_wr}, 32'h1);
    chk("st.wdata", data_wdata, 32'h1234_5678);
    chk("st.addr_bus", data_addr, 32'h0000_2004);
    next_cycle();
    drive(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("st.done", 1'b0, 1'b0, 1'b0);
    chk("st.rdata", rdata_m, 32'hDEAD_BEEF);
    next_cycle();

    // Misaligned load: error pulse, no request, no stall
    drive(1'b1, 1'b0, 32'h0000_1002, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("mis", 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_1002, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    ctl("mis.flush", 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("mis.after", 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Load flushed in ADDR before acceptance
    drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fa.idle", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    ctl("fa.addr", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
    ctl("fa.after", 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk("fa.rdata", rdata_m, 32'hDEAD_BEEF);

    // Load flushed in DATA; response two cycles later is discarded, no DONE
    drive(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fd.idle", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    ctl("fd.addr", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    ctl("fd.flush", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fd.wait", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    ctl("fd.dok", 1'b1, 1'b0, 1'b0);
    next_cycle();
    // Directly back in IDLE: a new load stalls immediately (a DONE cycle would not)
    drive(1'b1, 1'b0, 32'h0000_5000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fd.idle2", 1'b1, 1'b0, 1'b0);
    chk("fd.rdata", rdata_m, 32'hDEAD_BEEF);
    next_cycle();

    // That load reaches DATA, then reset abandons it; late data_ok ignored
    drive(1'b1, 1'b0, 32'h0000_5000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    ctl("rd.addr", 1'b1, 1'b1, 1'b0);
    chk("rd.addr_bus", data_addr, 32'h0000_5000);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("rd.rst", 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    ctl("rd.late", 1'b0, 1'b0, 1'b0);
    chk("rd.rdata0", rdata_m, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("rd.after", 1'b0, 1'b0, 1'b0);
    chk("rd.rdata1", rdata_m, 32'h0);
    chk("rd.addr_clr", data_addr, 32'h0);
    next_cycle();

    // Flush coincident with acceptance: drain response, discard it, skip DONE
    drive(1'b1, 1'b0, 32'h0000_6000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fc.idle", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_6000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    ctl("fc.addr", 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hAAAA_AAAA);
    ctl("fc.data", 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_7000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fc.idle2", 1'b1, 1'b0, 1'b0);
    chk("fc.rdata", rdata_m, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    ctl("fc.addr2", 1'b1, 1'b1, 1'b0);
    chk("fc.addr_bus", data_addr, 32'h0000_7000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
